// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The loader sits on the slave side, and the byte source / memory sits on the master side.
interface imem_loader_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  modport master (
    output in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: packs a big-endian byte stream into words and writes
// them until the halt word. Optional trailing checksum byte when LOADER_CHKSUM_EN is defined.
module imem_loader #(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] HALT_WORD = 32'hfc000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  imem_loader_if.slave    bus,
  output logic            cpu_rst,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [ADDR_W:0] word_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
`ifdef LOADER_CHKSUM_EN
    CHK   = 3'd3,
`endif
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        byte_cnt;
  logic [23:0]       word;   // first three bytes of the word being assembled
`ifdef LOADER_CHKSUM_EN
  logic [7:0]        sum;
`endif

  // Loader FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      addr         <= '0;
      byte_cnt     <= 2'd0;
      word         <= 24'h000000;
`ifdef LOADER_CHKSUM_EN
      sum          <= 8'h00;
`endif
      bus.in_ready <= 1'b0;
      bus.wr_en    <= 1'b0;
      bus.wr_addr  <= '0;
      bus.wr_data  <= 32'h00000000;
      cpu_rst      <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      word_count   <= '0;
    end else begin
      bus.wr_en <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state        <= RECV;
            addr         <= '0;
            byte_cnt     <= 2'd0;
`ifdef LOADER_CHKSUM_EN
            sum          <= 8'h00;
`endif
            bus.in_ready <= 1'b1;
            cpu_rst      <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            word_count   <= '0;
          end
        end
        RECV: begin
          if (bus.in_valid && bus.in_ready) begin
            word     <= {word[15:0], bus.in_data};
            byte_cnt <= byte_cnt + 2'd1;
`ifdef LOADER_CHKSUM_EN
            sum      <= sum + bus.in_data;
`endif
            if (byte_cnt == 2'd3) begin
              state        <= WRITE;
              bus.in_ready <= 1'b0;
              bus.wr_en    <= 1'b1;
              bus.wr_addr  <= addr;
              bus.wr_data  <= {word, bus.in_data};
            end
          end
        end
        WRITE: begin
          word_count <= word_count + 1'b1;
          if (bus.wr_data == HALT_WORD) begin
`ifdef LOADER_CHKSUM_EN
            state        <= CHK;
            bus.in_ready <= 1'b1;
`else
            state        <= DONE;
            busy         <= 1'b0;
            done         <= 1'b1;
            cpu_rst      <= 1'b0;
`endif
          end else if (addr == '1) begin
            // Memory full without a halt word: the last word is written, then fail.
            state <= ERR;
            busy  <= 1'b0;
            err   <= 1'b1;
          end else begin
            addr         <= addr + 1'b1;
            state        <= RECV;
            bus.in_ready <= 1'b1;
          end
        end
`ifdef LOADER_CHKSUM_EN
        CHK: begin
          if (bus.in_valid && bus.in_ready) begin
            bus.in_ready <= 1'b0;
            busy         <= 1'b0;
            if (8'(sum + bus.in_data) == 8'h00) begin
              state   <= DONE;
              done    <= 1'b1;
              cpu_rst <= 1'b0;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state        <= IDLE;
          bus.in_ready <= 1'b0;
          busy         <= 1'b0;
          cpu_rst      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: directed test-plan loads plus randomized images,
// with expected writes and final status derived from a word-level model of the image.
module tb_imem_loader;

  localparam int          AW    = 2;
  localparam int          DEPTH = 1 << AW;
  localparam logic [31:0] HALT  = 32'hfc000000;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          cpu_rst, busy, done, err;
  logic [AW:0]   word_count;
  int            checks = 0;
  int            fails = 0;
  wr_t           exp_q[$];
  wr_t           mon_e;

  imem_loader_if #(.ADDR_W(AW)) bus ();

  imem_loader #(.ADDR_W(AW), .HALT_WORD(HALT)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bus        (bus),
    .cpu_rst    (cpu_rst),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every memory write must match the oldest expected write.
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL spurious_write: addr %0d data %h, no write expected", bus.wr_addr, bus.wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 32'(bus.wr_addr), mon_e.addr);
        chk("wr_data", bus.wr_data, mon_e.data);
      end
    end
  end

  task automatic check_reset(input string tag);
    $display("[TB] reset check: %s", tag);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_wr_addr", 32'(bus.wr_addr), 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_word_count", 32'(word_count), 0);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Reference model: which words reach memory, the byte stream, and the final outcome.
  task automatic build(input logic [31:0] w[$], input bit bad, output logic [7:0] b[$],
                       output int nwr, output bit ed);
    logic [7:0] sum;
    bit         halted;
    wr_t        e;
    b.delete();
    nwr    = 0;
    sum    = 8'h00;
    halted = 1'b0;
    for (int i = 0; i < w.size(); i++) begin
      e.addr = i;
      e.data = w[i];
      exp_q.push_back(e);
      nwr++;
      for (int k = 3; k >= 0; k--) begin
        b.push_back(w[i][8*k +: 8]);
        sum = sum + w[i][8*k +: 8];
      end
      if (w[i] == HALT) begin
        halted = 1'b1;
        break;
      end
      if (i == DEPTH - 1) break;
    end
`ifdef LOADER_CHKSUM_EN
    if (halted) b.push_back(bad ? 8'(8'h01 - sum) : 8'(8'h00 - sum));
    ed = halted && !bad;
`else
    ed = halted;
`endif
  endtask

  task automatic send_stream(input logic [7:0] b[$], input bit throttle);
    int idx   = 0;
    int guard = 0;
    while (idx < b.size() && guard < 4000) begin
      @(negedge clk);
      guard++;
      bus.in_valid = throttle ? guard[0] : 1'b1;
      bus.in_data  = b[idx];
      if (bus.in_valid && bus.in_ready) idx++;
    end
    @(negedge clk) bus.in_valid = 1'b0;
    chk("stream_consumed", idx, b.size());
  endtask

  task automatic finish_check(input int nwr, input bit ed);
    int t = 0;
    while (!(done || err) && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk("load_terminates", done || err, 1);
    chk("done", done, ed);
    chk("err", err, !ed);
    chk("cpu_rst", cpu_rst, !ed);
    chk("busy", busy, 0);
    chk("in_ready_end", bus.in_ready, 0);
    chk("word_count", 32'(word_count), nwr);
    chk("writes_outstanding", exp_q.size(), 0);
  endtask

  task automatic run_load(input logic [31:0] w[$], input bit throttle, input bit bad);
    logic [7:0] b[$];
    int         nwr;
    bit         ed;
    pulse_start();
    build(w, bad, b, nwr, ed);
    send_stream(b, throttle);
    finish_check(nwr, ed);
  endtask

  initial begin
    logic [31:0] img[$];
    logic [31:0] w[$];
    logic [31:0] r;
    logic [7:0]  b[$];
    logic [7:0]  b1[$];
    logic [7:0]  b2[$];
    int          nwr;
    int          len;
    bit          ed;
    bit          halt_end;
    wr_t         e;

    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    img = '{32'h20080005, 32'h20090007, HALT};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset("power-on");

    run_load(img, 1'b0, 1'b0);
    run_load(img, 1'b1, 1'b0);

    w = '{32'h01020304, 32'h11223344, 32'hdeadbeef, 32'h00000001};
    run_load(w, 1'b0, 1'b0);

    // Reset after the 2nd byte of word 1; word 0 has already been written.
    pulse_start();
    e.addr = 0;
    e.data = img[0];
    exp_q.push_back(e);
    b = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09};
    send_stream(b, 1'b0);
    rst = 1'b1;
    #1;
    check_reset("mid-load");
    @(negedge clk) rst = 1'b0;
    run_load(img, 1'b0, 1'b0);

    // start during RECV must be ignored.
    pulse_start();
    build(img, 1'b0, b, nwr, ed);
    b1.delete();
    b2.delete();
    for (int i = 0; i < b.size(); i++) begin
      if (i < 2) b1.push_back(b[i]);
      else       b2.push_back(b[i]);
    end
    send_stream(b1, 1'b0);
    pulse_start();
    chk("mid_recv_busy", busy, 1);
    send_stream(b2, 1'b1);
    finish_check(nwr, ed);

    // start in DONE restarts from address 0.
    pulse_start();
    chk("restart_cpu_rst", cpu_rst, 1);
    chk("restart_done", done, 0);
    chk("restart_word_count", 32'(word_count), 0);
    chk("restart_busy", busy, 1);
    chk("restart_in_ready", bus.in_ready, 1);
    build(img, 1'b0, b, nwr, ed);
    send_stream(b, 1'b0);
    finish_check(nwr, ed);

`ifdef LOADER_CHKSUM_EN
    w = '{HALT};
    run_load(w, 1'b0, 1'b0);
    run_load(w, 1'b0, 1'b1);
`endif

    for (int it = 0; it < 24; it++) begin
      len      = $urandom_range(1, DEPTH);
      halt_end = (len < DEPTH) || ($urandom_range(0, 1) == 1);
      w.delete();
      for (int k = 0; k < len; k++) begin
        r = $urandom();
        if (r == HALT) r = r ^ 32'h00000001;
        w.push_back(r);
      end
      if (halt_end) w[len-1] = HALT;
      run_load(w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory loader for the 5-stage pipeline CPU. It accepts a byte stream over a valid/ready handshake, packs bytes big-endian into 32-bit instruction words, and drives the instruction memory's write port at consecutive word addresses. It holds the CPU core in reset until the program image is complete. The image ends with the halt word 32'hfc000000, which the loader also writes to memory.

## Interface
Parameters:
- ADDR_W, 10, word-address width (1024 words = 4 KB instruction memory)
- HALT_WORD, 32'hfc000000, end-of-image marker word

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERR
- in_valid  in  1  source has a byte
- in_data  in  8  stream byte
- in_ready  out  1  loader can accept a byte
- wr_en  out  1  instruction-memory write strobe
- wr_addr  out  ADDR_W  word address
- wr_data  out  32  instruction word
- cpu_rst  out  1  reset to the CPU core; active-high
- busy  out  1  load in progress
- done  out  1  image loaded; sticky until start or rst
- err  out  1  load failed; sticky until start or rst
- word_count  out  ADDR_W+1  number of words written in the current load

## Operation
- States: IDLE, RECV, WRITE, CHK (only when LOADER_CHKSUM_EN is defined), DONE, ERR.
- IDLE:
  - start → RECV; clears addr, byte counter, word_count, checksum, done and err.
- RECV:
  - in_ready=1.
  - Each accepted byte (in_valid&&in_ready at the clock edge) shifts into the word register. The first byte of a word becomes bits [31:24], the fourth becomes bits [7:0].
  - A 2-bit byte counter wraps after the 4th byte; the FSM then goes to WRITE.
- WRITE (exactly one cycle):
  - in_ready=0; wr_en=1; wr_addr=current addr; wr_data=packed word.
  - word_count increments.
  - If the word equals HALT_WORD: → CHK if enabled, otherwise → DONE.
  - Otherwise, if addr == 2^ADDR_W−1: → ERR (overflow; the word is still written).
  - Otherwise: addr+1, → RECV.
- DONE:
  - cpu_rst=0, done=1, in_ready=0.
- ERR:
  - cpu_rst=1, err=1, in_ready=0.
- start while in RECV, WRITE or CHK is ignored. start in DONE or ERR restarts the load exactly as from IDLE, and cpu_rst reasserts on the next edge.
- busy=1 in RECV, WRITE and CHK.
- cpu_rst=1 in every state except DONE.
- Bytes offered while in_ready=0 are not consumed.

## Timing
- Reset values: in_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_rst=1, busy=0, done=0, err=0, word_count=0. State after reset is IDLE.
- start sampled at edge T → in_ready=1 and busy=1 after T.
- 4th byte accepted at edge N:
  - wr_en is high for the cycle between edges N and N+1.
  - Memory captures the word at edge N+1.
  - in_ready returns to 1 after N+1 (unless the word was the halt word).
- Best-case throughput: 4 bytes per 5 cycles.
- Halt word written at edge N+1 (checksum disabled): done=1 and cpu_rst=0 after N+1.
- wr_addr and wr_data are registered outputs and are stable for the whole wr_en cycle.
- rst asserted mid-load: immediate return to reset values. Partially written memory contents are not cleaned up.

## Configuration
- LOADER_CHKSUM_EN defined:
  - The loader keeps a running 8-bit sum (mod 256) of every data byte, including the halt word's bytes.
  - After the halt write it enters CHK, with in_ready=1, and accepts exactly one checksum byte.
  - If sum + byte == 8'h00 → DONE, else → ERR.
- LOADER_CHKSUM_EN undefined:
  - No CHK state and no checksum logic. The halt write goes directly to DONE.

## Test plan
- Load image: bytes 20 08 00 05, 20 09 00 07, fc 00 00 00. Expect three writes: addr 0 = 32'h20080005, addr 1 = 32'h20090007, addr 2 = 32'hfc000000. Then done=1, cpu_rst=0, word_count=3.
- Throttled source: in_valid toggled every other cycle, plus in_valid held high during WRITE. Expect no byte lost or duplicated, and memory contents identical to the first test.
- Overflow, with ADDR_W=2 and four non-halt words. Expect the 4th write at addr 3, then err=1, cpu_rst=1, done=0.
- rst asserted after the 2nd byte of word 1, then start and the full image. Expect reset values, then a load starting at addr 0 that writes exactly the image.
- With LOADER_CHKSUM_EN, image "fc 00 00 00" plus checksum byte 8'h04: expect done=1. Same image with checksum byte 8'h05: expect err=1, cpu_rst=1.
- start pulsed mid-RECV: expect it to be ignored. start pulsed in DONE: expect cpu_rst=1, done=0, word_count=0 and addr restarting at 0.
